// File: rtl/trx_path_monitor_if.sv
// Handshake bundle between the board top / stimulus side and trx_path_monitor.
// master drives START/ERROR/SEL; slave (the monitor) drives the status outputs.
interface trx_path_monitor_if #(
    parameter int unsigned CHANNELS  = 10,
    parameter int unsigned CNT_WIDTH = 16
);
    localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                 start;
    logic [CHANNELS-1:0]  error;
    logic [SEL_W-1:0]     sel;
    logic                 path_rst;
    logic [CHANNELS-1:0]  locked;
    logic [CHANNELS-1:0]  fail;
    logic [CNT_WIDTH-1:0] err_cnt;
    logic [1:0]           state;
    logic                 done;

    modport master (
        output start, error, sel,
        input  path_rst, locked, fail, err_cnt, state, done
    );

    modport slave (
        input  start, error, sel,
        output path_rst, locked, fail, err_cnt, state, done
    );
endinterface

// File: rtl/trx_path_monitor.sv
// N-channel supervisor for ISERDES trx_path loopbacks: path reset, settle, lock, error count.
// Optional lock timeout enabled by defining TRX_MON_TIMEOUT_EN.
module trx_path_monitor #(
    parameter int unsigned CHANNELS      = 10,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned LOCK_CYCLES   = 256,
    parameter int unsigned RUN_CYCLES    = 0,
    parameter int unsigned LOCK_TIMEOUT  = 4096
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    trx_path_monitor_if.slave  bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RESET  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int unsigned LCK_W = $clog2(LOCK_CYCLES + 1);

    logic [1:0]           r_rst_sync;
    logic                 r_start_q;
    logic [CHANNELS-1:0]  r_erq;
    logic [2:0]           r_state;
    logic [31:0]          r_cnt;
    logic [CHANNELS-1:0]  r_locked;
    logic [CHANNELS-1:0]  r_fail;
    logic [CNT_WIDTH-1:0] r_err [CHANNELS];
    logic [LCK_W-1:0]     r_lck [CHANNELS];
    logic [CNT_WIDTH-1:0] r_err_cnt;
    logic                 w_start_p;
    logic                 w_clear;
    logic                 w_run;
    logic                 w_timeout;
    logic [1:0]           w_state_out;

    assign w_start_p = bus.start & ~r_start_q;
    assign w_clear   = (r_state == ST_RESET);
    assign w_run     = (r_state == ST_RUN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_sync <= 2'b00;
            r_start_q  <= 1'b0;
            r_erq      <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
            r_start_q  <= bus.start;
            r_erq      <= bus.error;
        end
    end

    // FSM holds in IDLE until the synchronised reset release has propagated.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (r_rst_sync[1]) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_p) begin
                        r_state <= ST_RESET;
                        r_cnt   <= '0;
                    end
                end
                ST_RESET: begin
                    if (w_start_p) begin
                        r_cnt <= '0;
                    end else if (r_cnt == RST_CYCLES - 1) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_SETTLE: begin
                    if (w_start_p) begin
                        r_state <= ST_RESET;
                        r_cnt   <= '0;
                    end else if (r_cnt == SETTLE_CYCLES - 1) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_RUN: begin
                    if (w_start_p) begin
                        r_state <= ST_RESET;
                        r_cnt   <= '0;
                    end else if (RUN_CYCLES != 0) begin
                        if (r_cnt == RUN_CYCLES - 1) begin
                            r_state <= ST_DONE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_start_p) begin
                        r_state <= ST_RESET;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef TRX_MON_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(LOCK_TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (!w_run) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_W'(LOCK_TIMEOUT)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Fires once, on the LOCK_TIMEOUT-th RUN cycle.
    assign w_timeout = w_run && (r_to_cnt == TO_W'(LOCK_TIMEOUT - 1));
`else
    localparam int unsigned unused_lock_timeout = LOCK_TIMEOUT;
    assign w_timeout = 1'b0;
`endif

    // Unlocked channels with FAIL set have timed out and no longer try to lock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_locked <= '0;
            r_fail   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_err[i] <= '0;
                r_lck[i] <= '0;
            end
        end else if (w_clear) begin
            r_locked <= '0;
            r_fail   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_err[i] <= '0;
                r_lck[i] <= '0;
            end
        end else if (w_run) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (r_locked[i]) begin
                    if (r_erq[i]) begin
                        r_fail[i] <= 1'b1;
                        if (r_err[i] != {CNT_WIDTH{1'b1}}) begin
                            r_err[i] <= r_err[i] + 1'b1;
                        end
                    end
                end else if (!r_fail[i]) begin
                    if (r_erq[i]) begin
                        r_lck[i] <= '0;
                    end else begin
                        r_lck[i] <= r_lck[i] + 1'b1;
                    end
                    if (!r_erq[i] && (r_lck[i] == LCK_W'(LOCK_CYCLES - 1))) begin
                        r_locked[i] <= 1'b1;
                    end else if (w_timeout) begin
                        r_fail[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else if (32'(bus.sel) < CHANNELS) begin
            r_err_cnt <= r_err[bus.sel];
        end else begin
            r_err_cnt <= '0;
        end
    end

    always_comb begin
        w_state_out = 2'd0;
        case (r_state)
            ST_RESET:          w_state_out = 2'd1;
            ST_SETTLE, ST_RUN: w_state_out = 2'd2;
            ST_DONE:           w_state_out = 2'd3;
            default:           w_state_out = 2'd0;
        endcase
    end

    assign bus.path_rst = (r_state == ST_IDLE) || (r_state == ST_RESET);
    assign bus.locked   = r_locked;
    assign bus.fail     = r_fail;
    assign bus.err_cnt  = r_err_cnt;
    assign bus.state    = w_state_out;
    assign bus.done     = (r_state == ST_DONE);
endmodule
